key_round_scheduler: RTL and testbench

- Sequences the AES-128 key-expansion engine through rounds 1..NUM_ROUNDS: pulses its enable, presents the round number and waits for its done pulse.
- Arbitrates the single round-key SRAM port between the expansion engine and the cipher datapath.
- Sits between the top-level AES control and the key-expansion/SRAM pair.

---
 rtl/key_round_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_key_round_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_round_scheduler.sv
// key_round_scheduler
//   Steps the AES-128 key-expansion engine through rounds 1..NUM_ROUNDS and
//   arbitrates the single round-key SRAM port between that engine and the
//   cipher datapath.
//   Optional macro: KEY_SCHED_TIMEOUT_EN adds a per-round WAIT watchdog that
//   moves to ERROR after TIMEOUT_CYC cycles without kx_done.
module key_round_scheduler #(
   parameter int unsigned NUM_ROUNDS  = 10,
   parameter int unsigned DATA_W      = 128,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              sched_done,
   output logic              sched_err,
   output logic              kx_enable,
   output logic [3:0]        kx_round_num,
   input  logic              kx_done,
   input  logic              kx_read,
   input  logic              kx_write,
   input  logic [ADDR_W-1:0] kx_addr,
   input  logic [DATA_W-1:0] kx_wdata,
   input  logic              cr_req,
   input  logic              cr_read,
   input  logic              cr_write,
   input  logic [ADDR_W-1:0] cr_addr,
   input  logic [DATA_W-1:0] cr_wdata,
   output logic              cr_gnt,
   output logic              sram_read,
   output logic              sram_write,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_NEXT,
      S_DONE,
      S_ERROR
   } state_e;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   state_e     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       busy_q, busy_d;
   logic       kx_enable_q, kx_enable_d;
   logic       sched_done_q, sched_done_d;

`ifdef KEY_SCHED_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC);
   logic [7:0] tmo_cnt_q, tmo_cnt_d;
   logic       sched_err_q, sched_err_d;
`endif

   // Next state, round register and watchdog count; abort overrides everything.
   always_comb begin
      // NOTE: every variable gets a default before the case, so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      round_d = round_q;
`ifdef KEY_SCHED_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d = S_ARM;
                  round_d = 4'd1;
               end
            end
            S_ARM: begin
               // kx_done is deliberately not looked at here.
               state_d = S_WAIT;
`ifdef KEY_SCHED_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
`ifdef KEY_SCHED_TIMEOUT_EN
               tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
               if (kx_done) begin
                  state_d = (round_q == LAST_ROUND) ? S_DONE : S_NEXT;
`ifdef KEY_SCHED_TIMEOUT_EN
               end else if (tmo_cnt_d == TMO_LAST) begin
                  // A done pulse on the same cycle takes the branch above.
                  state_d = S_ERROR;
`endif
               end
            end
            S_NEXT: begin
               // Idle cycle so the engine can return to its own idle state.
               round_d = round_q + 4'd1;
               state_d = S_ARM;
            end
            S_DONE: begin
               if (start) begin
                  state_d = S_ARM;
                  round_d = 4'd1;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ERROR: begin
               if (start) begin
                  state_d = S_ARM;
                  round_d = 4'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output flags precomputed from the next state so they leave a flop.
   always_comb begin
      busy_d       = (state_d == S_ARM) || (state_d == S_WAIT) || (state_d == S_NEXT);
      kx_enable_d  = (state_d == S_ARM);
      sched_done_d = (state_d == S_DONE);
`ifdef KEY_SCHED_TIMEOUT_EN
      sched_err_d  = (state_d == S_ERROR);
`endif
   end

   // State, round and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= S_IDLE;
         round_q      <= '0;
         busy_q       <= 1'b0;
         kx_enable_q  <= 1'b0;
         sched_done_q <= 1'b0;
`ifdef KEY_SCHED_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         sched_err_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         round_q      <= round_d;
         busy_q       <= busy_d;
         kx_enable_q  <= kx_enable_d;
         sched_done_q <= sched_done_d;
`ifdef KEY_SCHED_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         sched_err_q  <= sched_err_d;
`endif
      end
   end

   assign busy         = busy_q;
   assign kx_enable    = kx_enable_q;
   assign sched_done   = sched_done_q;
   assign kx_round_num = round_q;
`ifdef KEY_SCHED_TIMEOUT_EN
   assign sched_err    = sched_err_q;
`else
   assign sched_err    = 1'b0;
`endif

   // Ownership comes only from registered busy, so cr_req never reaches the kx side.
   assign cr_gnt = !busy_q && cr_req;

   // SRAM port mux: engine while busy, cipher when granted, otherwise all zero.
   always_comb begin
      sram_read  = 1'b0;
      sram_write = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (busy_q) begin
         sram_read  = kx_read;
         sram_write = kx_write;
         sram_addr  = kx_addr;
         sram_wdata = kx_wdata;
      end else if (cr_req) begin
         sram_read  = cr_read;
         sram_write = cr_write;
         sram_addr  = cr_addr;
         sram_wdata = cr_wdata;
      end
   end

endmodule

// File: tb/tb_key_round_scheduler.sv
// tb_key_round_scheduler
//   Directed sequence of expansion runs with randomized engine latency, stray
//   strobes and SRAM traffic. Expected outputs come from a timeline model:
//   enable/done cycles are derived arithmetically from the round latencies.
module tb_key_round_scheduler;

   localparam int NR = 10;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         rst, start, abort;
   logic         busy, sched_done, sched_err, kx_enable;
   logic [3:0]   kx_round_num;
   logic         kx_done, kx_read, kx_write;
   logic [15:0]  kx_addr;
   logic [127:0] kx_wdata;
   logic         cr_req, cr_read, cr_write;
   logic [15:0]  cr_addr;
   logic [127:0] cr_wdata;
   logic         cr_gnt, sram_read, sram_write;
   logic [15:0]  sram_addr;
   logic [127:0] sram_wdata;

   key_round_scheduler #(
      .NUM_ROUNDS (NR),
      .DATA_W     (128),
      .ADDR_W     (16),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .busy        (busy),
      .sched_done  (sched_done),
      .sched_err   (sched_err),
      .kx_enable   (kx_enable),
      .kx_round_num(kx_round_num),
      .kx_done     (kx_done),
      .kx_read     (kx_read),
      .kx_write    (kx_write),
      .kx_addr     (kx_addr),
      .kx_wdata    (kx_wdata),
      .cr_req      (cr_req),
      .cr_read     (cr_read),
      .cr_write    (cr_write),
      .cr_addr     (cr_addr),
      .cr_wdata    (cr_wdata),
      .cr_gnt      (cr_gnt),
      .sram_read   (sram_read),
      .sram_write  (sram_write),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cur_c  = -1;

   // Timeline model of one expansion run (cycle 0 = start presented).
   int lat  [1:NR];
   int en_c [1:NR+1];
   int dn_c [1:NR];
   int last_round = 0;
   bit last_err   = 1'b0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cur_c, obs, exp);
      end
   endtask

   function automatic int round_at(int c);
      int r = 0;
      for (int k = 1; k <= NR; k++) if (en_c[k] <= c) r = k;
      return r;
   endfunction

   function automatic bit is_arm(int c);
      for (int k = 1; k <= NR; k++) if (en_c[k] == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit is_next(int c);
      for (int k = 1; k < NR; k++) if (dn_c[k] + 1 == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // kind: 0 complete, 1 abort in WAIT of round 'at', 2 rst in WAIT of round
   // 'at', 3 engine never answers round 'at'.
   task automatic run(input int kind, input int at, input bit fixed_io,
                      input bit chain_in, input bit chain_out);
      int  stop_c, fin, a, end_c, exp_round;
      bit  exp_busy, exp_en, exp_done, exp_err, in_wait;
      logic         e_rd, e_wr;
      logic [15:0]  e_addr;
      logic [127:0] e_wd;
      en_c[1] = 1;
      for (int k = 1; k <= NR; k++) begin
         dn_c[k]   = en_c[k] + ((kind == 3 && k == at) ? 100000 : lat[k]);
         en_c[k+1] = dn_c[k] + 2;
      end
      fin = dn_c[NR] + 1;
      a   = en_c[at] + 1;
      case (kind)
         0:       stop_c = fin;
         3:       stop_c = en_c[at] + TO + 1;
         default: stop_c = a + 1;
      endcase
      end_c = chain_out ? fin : stop_c + 4;
      for (int c = (chain_in ? 1 : 0); c <= end_c; c++) begin
         cur_c    = c;
         exp_busy = (c >= 1) && (c < stop_c);
         exp_en   = exp_busy && is_arm(c);
         exp_done = (kind == 0) && (c == fin);
         exp_err  = (c == 0) ? last_err : ((kind == 3) && (c >= stop_c));
         if (c == 0)        exp_round = last_round;
         else if (exp_busy) exp_round = round_at(c);
         else if (kind == 2) exp_round = 0;
         else               exp_round = round_at(stop_c - 1);

         rst   = (kind == 2) && (c == a);
         abort = (kind == 1) && (c == a);
         start = (c == 0) || (chain_out && c == fin) ||
                 (!fixed_io && exp_busy && ($urandom_range(0, 3) == 0));
         in_wait = exp_busy && !is_arm(c) && !is_next(c);
         if (in_wait)       kx_done = (c == dn_c[round_at(c)]);
         else if (fixed_io) kx_done = 1'b0;
         else               kx_done = is_arm(c) ? 1'b1 : 1'($urandom_range(0, 1));

         if (fixed_io) begin
            cr_req = 1'b1; cr_read = 1'b1; cr_write = 1'b0; cr_addr = 16'h0020;
            kx_read = 1'b1; kx_write = 1'b0; kx_addr = 16'h0010;
         end else begin
            cr_req  = 1'($urandom_range(0, 1));
            cr_read = 1'($urandom_range(0, 1)); cr_write = 1'($urandom_range(0, 1));
            kx_read = 1'($urandom_range(0, 1)); kx_write = 1'($urandom_range(0, 1));
            cr_addr = 16'($urandom); kx_addr = 16'($urandom);
         end
         cr_wdata = rnd128();
         kx_wdata = rnd128();
         #1;
         if (exp_busy) begin
            e_rd = kx_read; e_wr = kx_write; e_addr = kx_addr; e_wd = kx_wdata;
         end else if (cr_req) begin
            e_rd = cr_read; e_wr = cr_write; e_addr = cr_addr; e_wd = cr_wdata;
         end else begin
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
         end
         chk("busy",       busy,         exp_busy);
         chk("kx_enable",  kx_enable,    exp_en);
         chk("sched_done", sched_done,   exp_done);
         chk("sched_err",  sched_err,    exp_err);
         chk("round_num",  kx_round_num, exp_round);
         chk("cr_gnt",     cr_gnt,       !exp_busy && cr_req);
         chk("sram_read",  sram_read,    e_rd);
         chk("sram_write", sram_write,   e_wr);
         chk("sram_addr",  sram_addr,    e_addr);
         chk("sram_wdata", sram_wdata,   e_wd);
         @(posedge clk);
         #1;
      end
      rst = 1'b0; abort = 1'b0; start = 1'b0; kx_done = 1'b0;
      case (kind)
         0:       begin last_round = NR; last_err = 1'b0; end
         1:       begin last_round = at; last_err = 1'b0; end
         2:       begin last_round = 0;  last_err = 1'b0; end
         default: begin last_round = at; last_err = 1'b1; end
      endcase
   endtask

   task automatic rand_lat();
      for (int k = 1; k <= NR; k++) lat[k] = $urandom_range(1, 24);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; kx_done = 1'b0;
      kx_read = 1'b1; kx_write = 1'b1; kx_addr = 16'h0010; kx_wdata = '1;
      cr_req = 1'b0; cr_read = 1'b1; cr_write = 1'b1; cr_addr = 16'h0020; cr_wdata = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",   busy,         1'b0);
      chk("rst_done",   sched_done,   1'b0);
      chk("rst_err",    sched_err,    1'b0);
      chk("rst_en",     kx_enable,    1'b0);
      chk("rst_round",  kx_round_num, 4'd0);
      chk("rst_gnt",    cr_gnt,       1'b0);
      chk("rst_sram_a", sram_addr,    16'h0000);
      chk("rst_sram_w", sram_wdata,   128'h0);
      chk("rst_sram_r", sram_read,    1'b0);
      rst = 1'b0;
      cr_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_gnt",  cr_gnt,    1'b1);
      chk("idle_addr", sram_addr, 16'h0020);

      // Full run, engine answers 20 cycles after each enable, cipher requesting.
      for (int k = 1; k <= NR; k++) lat[k] = 20;
      run(0, 1, 1'b1, 1'b0, 1'b0);

      // Random run ending with a restart from DONE, then abort in round 4.
      rand_lat();
      run(0, 1, 1'b0, 1'b0, 1'b1);
      rand_lat();
      run(1, 4, 1'b0, 1'b1, 1'b0);

      // abort and start together in IDLE: abort wins.
      cur_c = -1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      #1;
      chk("abst_busy",  busy,         1'b0);
      chk("abst_en",    kx_enable,    1'b0);
      chk("abst_round", kx_round_num, 4'(last_round));

      // Restart at round 1, first round at the watchdog boundary latency.
      rand_lat();
      lat[1] = TO;
      run(0, 1, 1'b0, 1'b0, 1'b0);

      // Synchronous reset during WAIT of round 6.
      rand_lat();
      run(2, 6, 1'b0, 1'b0, 1'b0);

`ifdef KEY_SCHED_TIMEOUT_EN
      // Engine never answers round 3, then start out of ERROR.
      rand_lat();
      run(3, 3, 1'b0, 1'b0, 1'b0);
      rand_lat();
      run(0, 1, 1'b0, 1'b0, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
